uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial receive end of the UART link driven by the arbitrator's tx line.
- Oversamples rx using the 16x rxclk_en strobe from baud_rate_gen and deserialises 8N1 frames, LSB first.
- Holds one received byte for the bus side with a ready/acknowledge handshake, plus frame-error and overrun flags.
- Exposes its FSM state on estado for bench monitoring.

Parameters:
- DATA_BITS, 8, data bits per frame (1..8).
- OVERSAMPLE, 16, rxclk_en ticks per bit period; must be even and at least 4.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- resetn  input  1  asynchronous active-low reset.
- rxclk_en  input  1  one-clock strobe at OVERSAMPLE x baud.
- rx  input  1  serial line; idle high; asynchronous to clock.
- rd_ack  input  1  one-clock pulse; consumer has taken data.
- data  output  DATA_BITS  last received byte.
- data_ready  output  1  data holds an unread byte.
- frame_error  output  1  stop bit of the held byte sampled low.
- overrun  output  1  a byte was overwritten before rd_ack.
- estado  output  3  current FSM state encoding.

Behaviour:
- Reset (async, resetn=0):
  - data=0, data_ready=0, frame_error=0, overrun=0, estado=000.
  - Synchroniser flops preset to 1; counters cleared.
  - Reset asserted mid-frame discards the partial frame.
- rx passes through a 2-flop synchroniser (rx_s) before any use.
- FSM states and estado encoding: IDLE=000, START=001, DATA=010, STOP=011. estado equals the state register.
- The sample counter (sc) and bit index (bi) advance only on cycles with rxclk_en=1. With rxclk_en=0 the FSM holds.
- IDLE:
  - On a tick with rx_s=0, go to START with sc=0.
- START:
  - Each tick increments sc.
  - On the tick where sc==OVERSAMPLE/2-1, sample rx_s. If 0, go to DATA with sc=0, bi=0. If 1, it was a glitch: return to IDLE with no output change.
- DATA:
  - Each tick increments sc.
  - On the tick where sc==OVERSAMPLE-1: shift rx_s into the MSB of a shift register (right shift, LSB first on the line), set sc=0, increment bi.
  - After DATA_BITS samples, go to STOP.
- STOP:
  - Each tick increments sc.
  - On the tick where sc==OVERSAMPLE-1, sample the stop bit and, on the next clock edge:
    - data is loaded with the assembled byte;
    - data_ready=1;
    - frame_error is set to the inverse of the stop sample;
    - FSM returns to IDLE.
  - A low stop bit still delivers the byte.
- Latency: data_ready rises one clock after the stop-sample tick, i.e. 2 sync clocks + (OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE) ticks after the falling start edge.
- Handshake and flag rules:
  - rd_ack with no load in the same cycle: clears data_ready, frame_error and overrun on the next edge.
  - Load with data_ready=1 and no rd_ack in the same cycle: data is overwritten, overrun=1 (sticky until rd_ack).
  - Load and rd_ack in the same cycle: the load wins. data_ready stays 1, overrun is unchanged, frame_error reflects the new byte.
  - rd_ack while data_ready=0 has no effect.
- Back-to-back frames: a start bit may begin on the first tick after returning to IDLE. No idle gap is required.
- rxclk_en held low forever: the FSM freezes in its current state. This is not an error.

Test Plan:
- 8N1 frame 0xA5 (line bits 1,0,1,0,0,1,0,1), stop=1, with ticks every 4 clocks -> data=0xA5, data_ready=1, frame_error=0, estado sequence 000,001,010,011,000. rd_ack -> data_ready=0.
- rx low for 4 ticks then high (glitch) -> estado 000→001→000; data_ready stays 0; data unchanged.
- Frame 0x3C with stop bit 0 -> data=0x3C, data_ready=1, frame_error=1. rd_ack clears both.
- Frames 0x11 then 0x22 with no rd_ack -> data=0x22, data_ready=1, overrun=1. Then rd_ack in the same cycle as a third frame's 0x33 load -> data=0x33, data_ready=1, overrun stays 1. The following rd_ack clears all flags.
- resetn pulsed low during the DATA state of frame 0x5A -> all outputs 0, estado=000 immediately. A following full 0x5A frame is received correctly.
- Two frames 0x00 and 0xFF back-to-back with no idle gap -> both delivered, each acked in turn, no frame or overrun errors.

Source files
------------

// File: rtl/uart_receiver_if.sv
// Bus-side handshake of the UART receiver: held byte, status flags and the
// consumer's read acknowledge.
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 rd_ack;
  logic [DATA_BITS-1:0] data;
  logic                 data_ready;
  logic                 frame_error;
  logic                 overrun;

  modport master (
    output data, data_ready, frame_error, overrun,
    input  rd_ack
  );

  modport slave (
    input  data, data_ready, frame_error, overrun,
    output rd_ack
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversamples the synchronised rx line on rxclk_en ticks,
// deserialises LSB first and holds one byte behind a ready/ack handshake.
module uart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  rxclk_en,
  input  logic                  rx,
  uart_receiver_if.master       bus,
  output logic [2:0]            estado
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    START = 3'b001,
    DATA  = 3'b010,
    STOP  = 3'b011
  } state_t;

  localparam int SC_W = $clog2(OVERSAMPLE);
  localparam int BI_W = $clog2(DATA_BITS + 1);
  localparam logic [SC_W-1:0] SC_HALF = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] SC_FULL = SC_W'(OVERSAMPLE - 1);
  localparam logic [BI_W-1:0] BI_LAST = BI_W'(DATA_BITS - 1);

  logic                 rx_meta_q, rx_s_q;
  state_t               state_q, state_d;
  logic [SC_W-1:0]      sc_q, sc_d;
  logic [BI_W-1:0]      bi_q, bi_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;
  logic                 load;

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    bi_d    = bi_q;
    shreg_d = shreg_q;
    load    = 1'b0;

    if (rxclk_en) begin
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_d = START;
            sc_d    = '0;
          end
        end
        START: begin
          // Mid-start-bit check rejects line glitches shorter than half a bit.
          if (sc_q == SC_HALF) begin
            sc_d    = '0;
            bi_d    = '0;
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
        DATA: begin
          if (sc_q == SC_FULL) begin
            shreg_d = (shreg_q >> 1) | (DATA_BITS'(rx_s_q) << (DATA_BITS - 1));
            sc_d    = '0;
            bi_d    = bi_q + 1'b1;
            if (bi_q == BI_LAST) state_d = STOP;
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
        STOP: begin
          if (sc_q == SC_FULL) begin
            load    = 1'b1;
            sc_d    = '0;
            state_d = IDLE;
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A load always beats a simultaneous acknowledge; overrun only latches when
  // an unread byte is overwritten without being taken in the same cycle.
  always_comb begin
    data_d  = data_q;
    ready_d = ready_q;
    fe_d    = fe_q;
    ovr_d   = ovr_q;
    if (load) begin
      data_d  = shreg_q;
      ready_d = 1'b1;
      fe_d    = ~rx_s_q;
      if (ready_q && !bus.rd_ack) ovr_d = 1'b1;
    end else if (bus.rd_ack && ready_q) begin
      ready_d = 1'b0;
      fe_d    = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      sc_q      <= '0;
      bi_q      <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      sc_q      <= sc_d;
      bi_q      <= bi_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      fe_q      <= fe_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.data        = data_q;
  assign bus.data_ready  = ready_q;
  assign bus.frame_error = fe_q;
  assign bus.overrun     = ovr_q;
  assign estado          = state_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus random frames,
// compared against a frame-level model of the held byte and its flags.
module tb_uart_receiver;
  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int TICK_DIV   = 4;
  localparam int BIT_CLKS   = OVERSAMPLE * TICK_DIV;
  localparam int WAIT_MAX   = 12 * BIT_CLKS;

  logic       clock    = 1'b0;
  logic       resetn   = 1'b0;
  logic       rxclk_en = 1'b0;
  logic       rx       = 1'b1;
  logic [2:0] estado;

  uart_receiver_if #(.DATA_BITS(DATA_BITS)) bus ();

  uart_receiver #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(OVERSAMPLE)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .rxclk_en (rxclk_en),
    .rx       (rx),
    .bus      (bus),
    .estado   (estado)
  );

  always #5 clock = ~clock;

  // Baud tick generator; tick_on lets a test freeze the receiver.
  bit tick_on = 1'b1;
  int tcnt    = 0;
  initial forever begin
    @(posedge clock);
    #1;
    rxclk_en = tick_on && (tcnt == TICK_DIV - 1);
    tcnt     = (tcnt + 1) % TICK_DIV;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame-level reference model of what the consumer should see.
  logic [7:0] m_data;
  bit         m_ready, m_fe, m_ovr;

  function automatic void model_reset();
    m_data = 8'h00; m_ready = 0; m_fe = 0; m_ovr = 0;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input bit stop_bit, input bit acked_same);
    if (m_ready && !acked_same) m_ovr = 1;
    m_data  = b;
    m_ready = 1;
    m_fe    = !stop_bit;
  endfunction

  function automatic void model_ack();
    m_ready = 0; m_fe = 0; m_ovr = 0;
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, ".data"},        bus.data,        m_data);
    check_eq({tag, ".data_ready"},  bus.data_ready,  m_ready);
    check_eq({tag, ".frame_error"}, bus.frame_error, m_fe);
    check_eq({tag, ".overrun"},     bus.overrun,     m_ovr);
  endtask

  // estado trace: records each change while logging is enabled.
  logic [2:0] log_q[$];
  bit         log_en = 0;
  always @(negedge clock)
    if (log_en && log_q.size() > 0 && estado != log_q[$]) log_q.push_back(estado);

  task automatic log_start();
    @(negedge clock);
    log_q.delete();
    log_q.push_back(estado);
    log_en = 1;
  endtask

  task automatic send_bit(input logic v);
    @(negedge clock);
    rx = v;
    repeat (BIT_CLKS - 1) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) send_bit(b[i]);
    send_bit(stop_bit);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic pulse_ack();
    @(negedge clock);
    bus.rd_ack = 1'b1;
    @(negedge clock);
    bus.rd_ack = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int t = 0;
    while (!bus.data_ready && t < WAIT_MAX) begin
      @(negedge clock);
      t++;
    end
    check_eq({tag, ".ready_seen"}, bus.data_ready, 1'b1);
  endtask

  // Raises rd_ack during exactly the cycle in which the stop bit is sampled.
  task automatic ack_at_load();
    int t = 0;
    int n = 0;
    while (estado != 3'b011 && t < WAIT_MAX) begin
      @(negedge clock);
      t++;
    end
    check_eq("ack_sync.stop_reached", estado, 3'b011);
    forever begin
      if (rxclk_en) n++;
      if (n == OVERSAMPLE || t > WAIT_MAX) break;
      @(negedge clock);
      t++;
    end
    bus.rd_ack = 1'b1;
    @(negedge clock);
    bus.rd_ack = 1'b0;
  endtask

  logic [2:0] seq_a5 [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
  logic [2:0] seq_gl [3] = '{3'd0, 3'd1, 3'd0};

  initial begin
    logic [7:0] b;
    bit         sb;
    bus.rd_ack = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    model_reset();
    check_outputs("reset");
    check_eq("reset.estado", estado, 3'b000);
    resetn = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clock);

    // 0xA5 with the full estado walk
    log_start();
    send_frame(8'hA5, 1'b1);
    idle_bits(1);
    log_en = 0;
    model_frame(8'hA5, 1, 0);
    check_outputs("a5");
    check_eq("a5.seq_len", log_q.size(), 5);
    for (int i = 0; i < 5; i++)
      check_eq("a5.seq", (i < log_q.size()) ? log_q[i] : 3'h7, seq_a5[i]);
    pulse_ack();
    model_ack();
    check_outputs("a5_ack");

    // Start-bit glitch
    log_start();
    @(negedge clock);
    rx = 1'b0;
    repeat (4 * TICK_DIV) @(negedge clock);
    rx = 1'b1;
    repeat (20 * TICK_DIV) @(negedge clock);
    log_en = 0;
    check_eq("glitch.seq_len", log_q.size(), 3);
    for (int i = 0; i < 3; i++)
      check_eq("glitch.seq", (i < log_q.size()) ? log_q[i] : 3'h7, seq_gl[i]);
    check_outputs("glitch");

    // Low stop bit still delivers, flags frame error
    send_frame(8'h3C, 1'b0);
    idle_bits(1);
    model_frame(8'h3C, 0, 0);
    check_outputs("fe");
    pulse_ack();
    model_ack();
    check_outputs("fe_ack");

    // Overrun, then ack colliding with a load
    send_frame(8'h11, 1'b1);
    model_frame(8'h11, 1, 0);
    send_frame(8'h22, 1'b1);
    model_frame(8'h22, 1, 0);
    check_outputs("ovr");
    fork
      send_frame(8'h33, 1'b1);
      ack_at_load();
    join
    model_frame(8'h33, 1, 1);
    check_outputs("ovr_same");
    pulse_ack();
    model_ack();
    check_outputs("ovr_ack");

    // Reset in the middle of a frame
    send_frame(8'h77, 1'b1);
    model_frame(8'h77, 1, 0);
    check_outputs("pre_rst");
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    check_eq("rst.mid_estado", estado, 3'b010);
    @(negedge clock);
    rx     = 1'b1;
    resetn = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    check_eq("rst.estado", estado, 3'b000);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    idle_bits(1);
    send_frame(8'h5A, 1'b1);
    model_frame(8'h5A, 1, 0);
    check_outputs("post_rst");
    pulse_ack();
    model_ack();

    // Back-to-back frames, each acked in turn
    fork
      begin
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
      end
      begin
        wait_ready("b2b0");
        model_frame(8'h00, 1, 0);
        check_outputs("b2b0");
        pulse_ack();
        model_ack();
        check_outputs("b2b0_ack");
        wait_ready("b2b1");
        model_frame(8'hFF, 1, 0);
        check_outputs("b2b1");
      end
    join
    pulse_ack();
    model_ack();
    check_outputs("b2b1_ack");

    // Frozen baud tick holds the FSM where it is
    @(negedge clock);
    rx = 1'b0;
    begin
      int t = 0;
      while (estado != 3'b001 && t < WAIT_MAX) begin
        @(negedge clock);
        t++;
      end
    end
    tick_on = 1'b0;
    repeat (200) @(negedge clock);
    check_eq("freeze.estado", estado, 3'b001);
    check_outputs("freeze");
    rx      = 1'b1;
    tick_on = 1'b1;
    repeat (20 * TICK_DIV) @(negedge clock);
    check_eq("thaw.estado", estado, 3'b000);

    // Random frames with random stop bits and acknowledges
    for (int k = 0; k < 12; k++) begin
      b  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      send_frame(b, sb);
      model_frame(b, sb, 0);
      check_outputs("rand");
      if (!sb) idle_bits(1);
      else     idle_bits($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        pulse_ack();
        model_ack();
        check_outputs("rand_ack");
      end
    end
    idle_bits(1);
    check_eq("end.estado", estado, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
